// File: rtl/sisc_pkg.sv
// Shared SISC definitions: fetch FSM states, HLT opcode and default address width.
package sisc_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam logic [3:0]  OP_HLT     = 4'hF;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_HOLD = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_buf.sv
// One-entry prefetch holding register with valid bit; flush has priority over write.
// Writes register on the edge; read-out is combinational from the held entry.
module ifetch_buf (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        wr_i,
    input  logic        rd_i,
    input  logic        flush_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        vld_o
);

    logic [31:0] dat_q;
    logic        vld_q;
    logic        vld_d;

    always_comb begin
        vld_d = vld_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (wr_i) begin
            vld_d = 1'b1;
        end else if (rd_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            if (wr_i) begin
                dat_q <= dat_i;
            end
            vld_q <= vld_d;
        end
    end

    assign dat_o = dat_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/ifetch.sv
// SISC instruction fetch: PC owner, memory req/rdy fetch, ir valid/take, branch redirect, HLT stop.
// Optional one-entry prefetch buffer under IFETCH_PREFETCH_EN; default build fetches one word per 2 cycles.
module ifetch
    import sisc_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter logic [3:0]  HLT_OP = OP_HLT
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_rdy,
    input  logic [31:0]       im_data,
    output logic [31:0]       ir,
    output logic              ir_vld,
    input  logic              ir_take,
    input  logic              br_ld,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       ir_q, ir_d;
    logic              req_q, req_d;
    logic              vld_q, vld_d;
    logic              halted_q, halted_d;
    logic              drop_q, drop_d;
    logic              accept;
    logic              take_hlt;

    assign accept   = req_q && im_rdy;
    assign take_hlt = ir_take && vld_q && (ir_q[31:28] == HLT_OP);

`ifdef IFETCH_PREFETCH_EN
    logic        buf_wr, buf_rd, buf_flush, buf_vld, got;
    logic [31:0] buf_dat;

    // A returned word is usable only if it was not fetched on a path a branch has abandoned.
    assign got = accept && !drop_q && !br_ld;

    ifetch_buf u_buf (
        .clk     (clk),
        .rst_f   (rst_f),
        .wr_i    (buf_wr),
        .rd_i    (buf_rd),
        .flush_i (buf_flush),
        .dat_i   (im_data),
        .dat_o   (buf_dat),
        .vld_o   (buf_vld)
    );
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        req_d    = req_q;
        vld_d    = vld_q;
        halted_d = halted_q;
        drop_d   = drop_q;
`ifdef IFETCH_PREFETCH_EN
        buf_wr    = 1'b0;
        buf_rd    = 1'b0;
        buf_flush = 1'b0;
`endif
        unique case (state_q)
            FETCH_REQ: begin
                req_d = 1'b1;
                if (accept) begin
                    if (drop_q || br_ld) begin
                        drop_d = 1'b0;
                        pc_d   = br_ld ? br_addr : pc_q;
                    end else begin
                        ir_d    = im_data;
                        vld_d   = 1'b1;
                        pc_d    = pc_q + ADDR_W'(1);
                        req_d   = 1'b0;
                        state_d = FETCH_HOLD;
                    end
                end else if (br_ld) begin
                    pc_d   = br_addr;
                    drop_d = req_q;
                end
            end
            FETCH_HOLD: begin
`ifdef IFETCH_PREFETCH_EN
                if (take_hlt) begin
                    vld_d     = 1'b0;
                    halted_d  = 1'b1;
                    req_d     = 1'b0;
                    drop_d    = 1'b0;
                    buf_flush = 1'b1;
                    state_d   = FETCH_HALT;
                end else begin
                    if (accept) begin
                        drop_d = 1'b0;
                    end
                    if (br_ld) begin
                        pc_d      = br_addr;
                        buf_flush = 1'b1;
                        drop_d    = req_q && !im_rdy;
                    end else if (got) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                    if (ir_take && (br_ld || !(buf_vld || got))) begin
                        vld_d   = 1'b0;
                        state_d = FETCH_REQ;
                    end else if (ir_take) begin
                        ir_d   = buf_vld ? buf_dat : im_data;
                        buf_rd = buf_vld;
                    end else begin
                        buf_wr = got;
                    end
                    // Keep fetching while the buffer will be empty after this edge.
                    req_d = (state_d == FETCH_REQ) ||
                            !((buf_vld && !buf_rd && !buf_flush) || buf_wr);
                end
`else
                req_d = 1'b0;
                if (take_hlt) begin
                    vld_d    = 1'b0;
                    halted_d = 1'b1;
                    state_d  = FETCH_HALT;
                end else begin
                    if (br_ld) begin
                        pc_d = br_addr;
                    end
                    if (ir_take) begin
                        vld_d   = 1'b0;
                        req_d   = 1'b1;
                        state_d = FETCH_REQ;
                    end
                end
`endif
            end
            FETCH_HALT: begin
                req_d = 1'b0;
            end
            default: begin
                req_d   = 1'b0;
                vld_d   = 1'b0;
                state_d = FETCH_REQ;
            end
        endcase
        // An outstanding request keeps its address until the memory accepts it.
        addr_d = (req_q && !im_rdy) ? addr_q : pc_d;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q  <= FETCH_REQ;
            pc_q     <= '0;
            addr_q   <= '0;
            ir_q     <= '0;
            req_q    <= 1'b0;
            vld_q    <= 1'b0;
            halted_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            vld_q    <= vld_d;
            halted_q <= halted_d;
            drop_q   <= drop_d;
        end
    end

    assign im_req  = req_q;
    assign im_addr = addr_q;
    assign ir      = ir_q;
    assign ir_vld  = vld_q;
    assign halted  = halted_q;
    assign pc      = pc_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch (default build): fetch, stall, branch discard, wrap, halt, async reset.
module tb_ifetch;

    logic        clk;
    logic        rst_f;
    logic        im_req;
    logic [15:0] im_addr;
    logic        im_rdy;
    logic [31:0] im_data;
    logic [31:0] ir;
    logic        ir_vld;
    logic        ir_take;
    logic        br_ld;
    logic [15:0] br_addr;
    logic        halted;
    logic [15:0] pc;

    int checks   = 0;
    int failures = 0;

    ifetch dut (
        .clk     (clk),
        .rst_f   (rst_f),
        .im_req  (im_req),
        .im_addr (im_addr),
        .im_rdy  (im_rdy),
        .im_data (im_data),
        .ir      (ir),
        .ir_vld  (ir_vld),
        .ir_take (ir_take),
        .br_ld   (br_ld),
        .br_addr (br_addr),
        .halted  (halted),
        .pc      (pc)
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 32'h0000_0001;
            16'h0001: mem_word = 32'h0000_0002;
            16'h0002: mem_word = 32'h0000_0003;
            16'h0010: mem_word = 32'hF000_0000;
            default:  mem_word = {16'hC0DE, a};
        endcase
    endfunction

    assign im_data = mem_word(im_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_f   = 1'b1;
        im_rdy  = 1'b0;
        ir_take = 1'b0;
        br_ld   = 1'b0;
        br_addr = 16'h0000;
        #1 rst_f = 1'b0;
        cyc(2);
        chk("rst_req",    32'(im_req), 0);
        chk("rst_vld",    32'(ir_vld), 0);
        chk("rst_pc",     32'(pc),     0);
        chk("rst_ir",     ir,          0);
        chk("rst_halted", 32'(halted), 0);

        // Always-ready memory, ir_take held high
        rst_f = 1'b1; im_rdy = 1'b1; ir_take = 1'b1;
        cyc(1);
        chk("seq_req0",  32'(im_req),  1);
        chk("seq_addr0", 32'(im_addr), 0);
        chk("seq_vld0",  32'(ir_vld),  0);
        cyc(1);
        chk("seq_ir1",  ir,          32'h1);
        chk("seq_pc1",  32'(pc),     1);
        chk("seq_vld1", 32'(ir_vld), 1);
        cyc(1);
        chk("seq_gap1",  32'(ir_vld),  0);
        chk("seq_addr1", 32'(im_addr), 1);
        cyc(1);
        chk("seq_ir2", ir,      32'h2);
        chk("seq_pc2", 32'(pc), 2);
        cyc(1);
        chk("seq_gap2", 32'(ir_vld), 0);
        cyc(1);
        chk("seq_ir3",  ir,          32'h3);
        chk("seq_pc3",  32'(pc),     3);
        chk("seq_vld3", 32'(ir_vld), 1);
        ir_take = 1'b0; im_rdy = 1'b0;
        cyc(2);
        chk("hold_ir",  ir,          32'h3);
        chk("hold_vld", 32'(ir_vld), 1);
        chk("hold_req", 32'(im_req), 0);

        // im_rdy delayed 3 cycles: request stable for 4 cycles
        ir_take = 1'b1;
        cyc(1);
        ir_take = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc(1);
            chk("stall_req",  32'(im_req),  1);
            chk("stall_addr", 32'(im_addr), 3);
            chk("stall_ir",   ir,           32'h3);
            chk("stall_vld",  32'(ir_vld),  0);
        end
        im_rdy = 1'b1;
        cyc(1);
        chk("stall_ir_new", ir,          32'hC0DE_0003);
        chk("stall_vld1",   32'(ir_vld), 1);
        chk("stall_pc",     32'(pc),     4);
        im_rdy = 1'b0;

        // Branch during an outstanding request discards the returned word
        ir_take = 1'b1;
        cyc(1);
        ir_take = 1'b0; br_ld = 1'b1; br_addr = 16'h0040;
        cyc(1);
        chk("br_pc",       32'(pc),      32'h40);
        chk("br_addr_old", 32'(im_addr), 4);
        br_ld = 1'b0; im_rdy = 1'b1;
        cyc(1);
        chk("br_drop_vld", 32'(ir_vld),  0);
        chk("br_addr_new", 32'(im_addr), 32'h40);
        chk("br_req",      32'(im_req),  1);
        cyc(1);
        chk("br_ir",  ir,          32'hC0DE_0040);
        chk("br_vld", 32'(ir_vld), 1);
        chk("br_pc1", 32'(pc),     32'h41);
        im_rdy = 1'b0;

        // PC wrap from 0xFFFF
        br_ld = 1'b1; br_addr = 16'hFFFF; ir_take = 1'b1;
        cyc(1);
        br_ld = 1'b0; ir_take = 1'b0;
        chk("wrap_addr", 32'(im_addr), 32'hFFFF);
        im_rdy = 1'b1;
        cyc(1);
        chk("wrap_ir", ir,      32'hC0DE_FFFF);
        chk("wrap_pc", 32'(pc), 0);
        im_rdy = 1'b0; ir_take = 1'b1;
        cyc(1);
        ir_take = 1'b0;
        chk("wrap_next_addr", 32'(im_addr), 0);
        chk("wrap_next_req",  32'(im_req),  1);

        // Redirect to the HLT word, then take it together with a branch
        br_ld = 1'b1; br_addr = 16'h0010;
        cyc(1);
        br_ld = 1'b0; im_rdy = 1'b1;
        cyc(2);
        chk("hlt_ir",  ir,          32'hF000_0000);
        chk("hlt_vld", 32'(ir_vld), 1);
        ir_take = 1'b1; br_ld = 1'b1; br_addr = 16'h0080;
        cyc(1);
        chk("hlt_halted", 32'(halted), 1);
        chk("hlt_vld0",   32'(ir_vld), 0);
        chk("hlt_pc",     32'(pc),     32'h11);
        br_addr = 16'h0020;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("halt_noreq", 32'(im_req), 0);
        end
        chk("halt_pc_kept", 32'(pc),     32'h11);
        chk("halt_still",   32'(halted), 1);
        chk("halt_vld",     32'(ir_vld), 0);

        // Reset out of HALT, fetch one word, then reset mid-request
        ir_take = 1'b0; br_ld = 1'b0;
        rst_f = 1'b0;
        #2;
        chk("rst2_halted", 32'(halted), 0);
        rst_f = 1'b1;
        cyc(2);
        chk("rst2_ir", ir,      32'h1);
        chk("rst2_pc", 32'(pc), 1);
        ir_take = 1'b1; im_rdy = 1'b0;
        cyc(1);
        ir_take = 1'b0;
        chk("mid_req", 32'(im_req), 1);
        chk("mid_pc",  32'(pc),     1);
        rst_f = 1'b0;
        #1;
        chk("arst_req", 32'(im_req), 0);
        chk("arst_vld", 32'(ir_vld), 0);
        chk("arst_pc",  32'(pc),     0);
        rst_f = 1'b1; im_rdy = 1'b1;
        cyc(1);
        chk("resume_addr", 32'(im_addr), 0);
        chk("resume_req",  32'(im_req),  1);
        cyc(1);
        chk("resume_ir", ir,      32'h1);
        chk("resume_pc", 32'(pc), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the SISC processor: owns the program counter, reads 32-bit words from instruction memory over a request/ready handshake, and presents each one to the processor as `ir` with a valid/take handshake. It sits between instruction memory and the `ir` input of the SISC top level. It redirects the PC on branches and stops fetching on HLT.

## Interface
- `ADDR_W`, 16: PC and memory address width.
- `HLT_OP`, 4'hF: opcode (`ir[31:28]`) that halts fetching.

Ports:
- `clk`  in  1: system clock, rising-edge.
- `rst_f`  in  1: asynchronous, active-low reset.
- `im_req`  out  1: memory read request.
- `im_addr`  out  ADDR_W: read address.
- `im_rdy`  in  1: memory returns `im_data` this cycle.
- `im_data`  in  32: instruction word.
- `ir`  out  32: current instruction to the processor.
- `ir_vld`  out  1: `ir` holds an unconsumed instruction.
- `ir_take`  in  1: processor consumes `ir` this cycle.
- `br_ld`  in  1: load PC with `br_addr`.
- `br_addr`  in  ADDR_W: branch target.
- `halted`  out  1: HLT consumed; fetching stopped.
- `pc`  out  ADDR_W: address of the next word to fetch.

## Operation
- One clock; reset is asynchronous and active-low.
- Reset values: `pc`=0, `ir`=0, `ir_vld`=0, `im_req`=0, `halted`=0. State=REQ.
- States: REQ, HOLD, HALT.
- REQ:
  - Drive `im_req`=1 and `im_addr`=`pc`.
  - Hold both stable until `im_rdy` is sampled high.
  - On `im_rdy`: `ir`<=`im_data`, `ir_vld`<=1, `pc`<=`pc`+1, go to HOLD.
- HOLD:
  - `im_req`=0 (unless PREFETCH_EN). `ir_vld`=1; `ir` is stable.
  - On `ir_take`, if `ir[31:28]`==HLT_OP: `ir_vld`<=0, `halted`<=1, go to HALT.
  - On `ir_take` otherwise: `ir_vld`<=0, go to REQ.
- HALT: `im_req`=0, `ir_vld`=0. Ignores all inputs. Only `rst_f` exits.
- `ir_take` while `ir_vld`=0 is ignored.
- PC arithmetic: `pc`+1 is modulo 2^ADDR_W, so all-ones wraps to 0.
- `br_ld`:
  - Sampled in any state except HALT; `pc`<=`br_addr`.
  - In HOLD together with `ir_take`: the next request uses `br_addr`.
  - In REQ with the request outstanding: the handshake completes normally on `im_rdy`, but the word is discarded (`ir_vld` stays 0) and REQ reissues at `br_addr`.
  - If `br_ld` coincides with `im_rdy`: the word is discarded and the new PC is used.
- Simultaneous `br_ld` and a HLT take: the halt wins.
- Reset mid-handshake: `im_req` drops immediately (asynchronous).

## Timing
- `ir_take` at edge N → `im_req` high in cycle N+1.
- Memory with `im_rdy` in its first request cycle → `ir_vld` at N+2. Minimum issue interval is 2 cycles per instruction.
- `im_data` is registered; there are no combinational paths from `im_data` or `ir_take` to outputs.
- `br_ld` takes effect at the edge it is sampled; `im_addr` reflects the new PC the following cycle.

## Configuration
- `IFETCH_PREFETCH_EN` defined:
  - Adds a one-entry prefetch buffer. In HOLD, `im_req` fetches `pc` into the buffer and advances `pc`.
  - On `ir_take` with the buffer full: `ir` loads from the buffer on the same edge and `ir_vld` stays 1, giving a 1 instruction/cycle sustained rate.
  - `br_ld` flushes the buffer and cancels the in-flight word.
  - HLT taken: the buffer is discarded.
- `IFETCH_PREFETCH_EN` undefined: no buffer; behaviour exactly as in Operation.

## Structure
- Shared package `sisc_pkg` holds:
  - the fetch state enum (REQ, HOLD, HALT);
  - the `OP_HLT` constant (4'hF) used as the HLT_OP default;
  - the `ADDR_W` default constant.
- The optional prefetch buffer is one sub-module, `ifetch_buf`: 32-bit data plus address-free valid bit, with `flush`. It is instantiated only under `IFETCH_PREFETCH_EN`.

## Test plan
- Reset release, memory always ready, words 0x1..0x3 at addresses 0..2, `ir_take` held high → `ir` sequence 0x00000001, 0x00000002, 0x00000003; `pc` = 1, 2, 3; `ir_vld` low every other cycle (no prefetch).
- `im_rdy` delayed 3 cycles → `im_addr` and `im_req` stable for all 4 cycles; `ir` updates only on the `im_rdy` edge.
- `br_ld`=1 with `br_addr`=0x0040 during an outstanding request → the returned word is discarded (`ir_vld` stays 0), next `im_addr`=0x0040, and `ir` = mem[0x40].
- HLT word 0xF0000000 taken → `halted`=1, `im_req` stays 0 for 20 cycles, and `br_ld` has no effect.
- `pc`=0xFFFF fetch → next `im_addr`=0x0000.
- `rst_f` pulsed low mid-request → `im_req`, `ir_vld` and `pc` are 0 immediately; fetch resumes at address 0 after release.
